// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: state encoding,
// datapath width, default reset PC and the fetch-buffer entry layout.
package mips_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between fetch and decode. Slot 0 is always
// the head, so the head word cannot move while it is waiting to be popped.
// Flush dominates push; push into a full buffer is accepted only when the
// head pops the same edge.
module fetch_buffer
    import mips_fetch_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr,
    output logic            full,
    output logic            empty
);

    logic [1:0]   count;
    fetch_entry_t slot0;
    fetch_entry_t slot1;
    fetch_entry_t din;
    logic         push_ok;
    logic         pop_ok;

    assign din     = '{pc: push_pc, instr: push_instr};
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign head_pc    = slot0.pc;
    assign head_instr = slot0.instr;

    // Occupancy count: the only state that needs a reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge values, independent of statement order.
        if (!Rst_n) begin
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push_ok && !pop_ok) begin
            count <= count + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count <= count - 2'd1;
        end
    end

    // Entry storage: shift on pop, write the first free slot on push.
    // NOTE: the data slots are deliberately not reset; count alone says
    // which slots are meaningful, so resetting the payload buys nothing.
    always_ff @(posedge Clk) begin
        if (!flush) begin
            if (pop_ok) begin
                if (push_ok && count == 2'd1) slot0 <= din;
                else                          slot0 <= slot1;
                if (push_ok && count == 2'd2) slot1 <= din;
            end else if (push_ok) begin
                if (count == 2'd0) slot0 <= din;
                else               slot1 <= din;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the combinational
// instruction memory and feeds decode through a two-entry buffer. A taken
// branch/jump on Redirect flushes the buffer and restarts at the target.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (out-of-range PC and
// misaligned redirect targets stop fetch in a sticky FAULT state).
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    output logic [31:0] InstrPCPlus4,
    output logic        Fault
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  target_aligned;
    logic         buf_full;
    logic         buf_empty;
    logic         pop;
    logic         push;
    logic         fault_hit;
    logic         redirect_ok;

    assign target_aligned = {RedirectTarget[31:2], 2'b00};
    assign ImemAddress    = pc;
    assign InstrValid     = !buf_empty;
    assign pop            = InstrValid && InstrReady;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    logic bad_target;
    logic out_of_range;

    // A legal redirect replaces the current fetch, so the range check only
    // applies to a PC that would actually be fetched this edge.
    assign bad_target   = Redirect && (RedirectTarget[1:0] != 2'b00);
    assign out_of_range = !Redirect && (pc[31:2] >= IMEM_LIMIT);
    assign fault_hit    = (state == ST_RUN) && (bad_target || out_of_range);
    assign Fault        = (state == ST_FAULT);
`else
    logic unused_cfg;

    assign unused_cfg = ^{RedirectTarget[1:0], IMEM_WORDS};
    assign fault_hit  = 1'b0;
    assign Fault      = 1'b0;
`endif

    // Redirect is ignored once faulted and never applied when it faults.
    assign redirect_ok = Redirect && (state != ST_FAULT) && !fault_hit;
    assign push        = (state == ST_RUN) && !Redirect && !fault_hit &&
                         (!buf_full || pop);

    fetch_buffer u_buffer (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_ok),
        .push_pc    (pc),
        .push_instr (ImemInstruction),
        .head_pc    (InstrPC),
        .head_instr (Instruction),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    assign InstrPCPlus4 = InstrPC + 32'd4;

    // Fetch FSM and program counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
            pc    <= RESET_PC_ALIGNED;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_RUN;
                    if (redirect_ok) pc <= target_aligned;
                end
                ST_RUN: begin
                    if (fault_hit)        state <= ST_FAULT;
                    else if (redirect_ok) pc    <= target_aligned;
                    else if (push)        pc    <= pc + 32'd4;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Stimulus pushes hand-computed
// {pc, instr} pairs into a scoreboard; a negedge monitor pops one entry for
// every accepted transfer. Memory model: word i holds i*3.
// Build with FETCH_BOUNDS_CHECK_EN defined to exercise the fault cases.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic [31:0] InstrPCPlus4;
    logic        Fault;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic        hold_valid = 1'b0;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(128)) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .ImemAddress     (ImemAddress),
        .ImemInstruction (ImemInstruction),
        .Redirect        (Redirect),
        .RedirectTarget  (RedirectTarget),
        .InstrValid      (InstrValid),
        .InstrReady      (InstrReady),
        .Instruction     (Instruction),
        .InstrPC         (InstrPC),
        .InstrPCPlus4    (InstrPCPlus4),
        .Fault           (Fault)
    );

    always #5 Clk = ~Clk;

    assign ImemInstruction = (ImemAddress >> 2) * 32'd3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb_q.push_back(e);
    endtask

    task automatic start(input logic ready);
        Rst_n = 1'b0;
        step();
        step();
        Redirect   = 1'b0;
        InstrReady = ready;
        Rst_n      = 1'b1;
    endtask

    task automatic end_phase(input string name);
        check({name, "_sb_drained"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Scoreboard monitor plus a head-stability check while decode stalls.
    always @(negedge Clk) begin
        if (Rst_n && InstrValid && InstrReady) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got transfer pc %h instr %h, required none",
                         InstrPC, Instruction);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_instr", Instruction, mon_e.instr);
                check("sb_pc", InstrPC, mon_e.pc);
                check("sb_pc_plus4", InstrPCPlus4, mon_e.pc + 32'd4);
            end
        end
        if (hold_valid && Rst_n && InstrValid) begin
            check("stall_stable_instr", Instruction, hold_instr);
            check("stall_stable_pc", InstrPC, hold_pc);
        end
        hold_valid = Rst_n && InstrValid && !InstrReady && !Redirect;
        hold_instr = Instruction;
        hold_pc    = InstrPC;
    end

    initial begin
        Rst_n          = 1'b0;
        InstrReady     = 1'b0;
        Redirect       = 1'b0;
        RedirectTarget = 32'h0;
        step();
        step();
        check("reset_valid", InstrValid, 0);
        check("reset_addr", ImemAddress, 32'h0);
        check("reset_fault", Fault, 0);

        // Streaming from reset: 0,3,6,9 at PC 0,4,8,12.
        sb_push(32'h0, 0);
        sb_push(32'h4, 3);
        sb_push(32'h8, 6);
        sb_push(32'hC, 9);
        start(1'b1);
        step();
        check("p1_idle_no_valid", InstrValid, 0);
        step();
        check("p1_first_valid", InstrValid, 1);
        repeat (4) step();
        InstrReady = 1'b0;
        step();
        end_phase("p1");

        // Decode stall: two words buffered, PC frozen at 8, then resume.
        start(1'b0);
        repeat (5) step();
        check("p2_addr_held", ImemAddress, 32'h8);
        check("p2_valid", InstrValid, 1);
        check("p2_head", Instruction, 0);
        sb_push(32'h0, 0);
        sb_push(32'h4, 3);
        sb_push(32'h8, 6);
        InstrReady = 1'b1;
        step();
        check("p2_resume_addr", ImemAddress, 32'hC);
        step();
        step();
        InstrReady = 1'b0;
        step();
        end_phase("p2");

        // Redirect to 0x40 with a full buffer and decode accepting.
        start(1'b0);
        repeat (3) step();
        check("p3_full_addr", ImemAddress, 32'h8);
        sb_push(32'h0, 0);
        sb_push(32'h40, 48);
        InstrReady     = 1'b1;
        Redirect       = 1'b1;
        RedirectTarget = 32'h40;
        step();
        Redirect = 1'b0;
        check("p3_flush_valid", InstrValid, 0);
        check("p3_redirect_addr", ImemAddress, 32'h40);
        step();
        check("p3_target_valid", InstrValid, 1);
        step();
        InstrReady = 1'b0;
        step();
        end_phase("p3");

        // Asynchronous reset mid-stream with a full buffer.
        start(1'b0);
        repeat (3) step();
        check("p4_full_valid", InstrValid, 1);
        Rst_n = 1'b0;
        #1;
        check("p4_async_valid", InstrValid, 0);
        check("p4_async_addr", ImemAddress, 32'h0);
        check("p4_async_fault", Fault, 0);
        step();
        sb_push(32'h0, 0);
        InstrReady = 1'b1;
        Rst_n      = 1'b1;
        step();
        step();
        check("p4_restart_pc", InstrPC, 32'h0);
        step();
        InstrReady = 1'b0;
        step();
        end_phase("p4");

        // Misaligned redirect target 0x42.
        start(1'b0);
        step();
        Redirect       = 1'b1;
        RedirectTarget = 32'h42;
        step();
        Redirect = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
        check("p5_fault", Fault, 1);
        InstrReady = 1'b1;
        repeat (3) step();
        check("p5_no_valid", InstrValid, 0);
        Redirect       = 1'b1;
        RedirectTarget = 32'h0;
        step();
        Redirect = 1'b0;
        step();
        check("p5_fault_sticky", Fault, 1);
        check("p5_redirect_ignored", InstrValid, 0);
        InstrReady = 1'b0;
`else
        check("p5_no_fault", Fault, 0);
        check("p5_truncated_addr", ImemAddress, 32'h40);
        sb_push(32'h40, 48);
        step();
        InstrReady = 1'b1;
        step();
        InstrReady = 1'b0;
        check("p5_fault_after", Fault, 0);
        step();
`endif
        end_phase("p5");

        // Last in-range word 0x1FC (word 127 -> 381), then PC 0x200.
        start(1'b0);
        step();
        Redirect       = 1'b1;
        RedirectTarget = 32'h1FC;
        step();
        Redirect = 1'b0;
        sb_push(32'h1FC, 381);
        step();
        InstrReady = 1'b1;
        check("p6_pc_plus4", InstrPCPlus4, 32'h200);
`ifdef FETCH_BOUNDS_CHECK_EN
        step();
        check("p6_fault", Fault, 1);
        repeat (3) step();
        check("p6_no_valid", InstrValid, 0);
        InstrReady = 1'b0;
`else
        sb_push(32'h200, 384);
        step();
        step();
        InstrReady = 1'b0;
        check("p6_no_fault", Fault, 0);
`endif
        step();
        end_phase("p6");

`ifndef FETCH_BOUNDS_CHECK_EN
        // PC wrap: 0xFFFF_FFFC + 4 -> 0.
        start(1'b0);
        step();
        Redirect       = 1'b1;
        RedirectTarget = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0;
        sb_push(32'hFFFF_FFFC, 32'hBFFF_FFFD);
        sb_push(32'h0, 0);
        step();
        InstrReady = 1'b1;
        check("p7_plus4_wrap", InstrPCPlus4, 32'h0);
        step();
        step();
        InstrReady = 1'b0;
        step();
        end_phase("p7");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the MIPS pipeline: owns the program counter, drives the address of the combinational instruction memory, and hands fetched words to the decode stage through a valid/ready handshake. A two-entry buffer decouples fetch from decode stalls, and a single redirect port applies branch/jump targets with a full flush. Sits between the instruction memory and the IF/ID pipeline register.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- IMEM_WORDS, 128: instruction memory depth in words (bounds check only).
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  reset, asynchronous assert, active-low.
- ImemAddress  output  32  byte address to instruction memory; bits [1:0] always 0.
- ImemInstruction  input  32  word returned combinationally for ImemAddress in the same cycle.
- Redirect  input  1  branch/jump taken; flush and restart at RedirectTarget.
- RedirectTarget  input  32  new PC.
- InstrValid  output  1  buffer head holds a valid instruction.
- InstrReady  input  1  decode accepts head this cycle.
- Instruction  output  32  head instruction word.
- InstrPC  output  32  PC of head instruction.
- InstrPCPlus4  output  32  InstrPC + 4, mod 2^32.
- Fault  output  1  fetch fault (constant 0 unless FETCH_BOUNDS_CHECK_EN).

## Operation
- States: IDLE (one cycle after reset release, no fetch), RUN, FAULT (only with macro).
- IDLE -> RUN unconditionally on first edge after reset release.
- RUN, fetch: ImemAddress = {PC[31:2],2'b00}. Push {PC, ImemInstruction} into buffer and PC <= PC + 4 when buffer has space at this edge (not full, or full with head popped this cycle).
- Pop: head removed when InstrValid && InstrReady at the edge.
- Redirect (priority over fetch push): buffer cleared, PC <= {RedirectTarget[31:2],2'b00}; any pop completing the same edge still counts as accepted by decode; no push that edge.
- Redirect in IDLE: PC loaded, state still moves to RUN.
- PC arithmetic 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0.
- Outputs Instruction/InstrPC/InstrPCPlus4 are don't-care but stable-at-head while InstrValid=0; they must not change while InstrValid=1 and InstrReady=0.
- Reset (any time, including mid-fetch or FAULT): PC=RESET_PC, buffer empty, state IDLE, InstrValid=0, Fault=0, ImemAddress=RESET_PC.

## Timing
- Reset release -> first edge: IDLE->RUN; second edge: RESET_PC word pushed; InstrValid=1 after it (latency 2 edges).
- Fetch-to-valid latency 1 edge; sustained throughput 1 instruction/cycle with InstrReady held high.
- Redirect sampled at edge N: InstrValid=0 after N; target word valid after N+1.
- InstrReady low: buffer fills after 2 pushes, fetch stalls with PC frozen at next unfetched address; resumes same edge InstrReady returns high.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined: in RUN, if PC[31:2] >= IMEM_WORDS, or Redirect with RedirectTarget[1:0] != 0, no push/PC update; enter FAULT, Fault=1 from next edge. FAULT: no fetch, buffer drains normally, Redirect ignored, exit only via reset.
- Undefined: no checks, FAULT unreachable, Fault tied 0, misaligned targets silently truncated.

## Structure
- Shared package mips_fetch_pkg: state encoding constants (IDLE/RUN/FAULT), instruction/address width constant, default RESET_PC.
- One sub-module: fetch_buffer, 2-entry FIFO of {pc[31:0], instr[31:0]} with push, pop, flush, full, empty; flush dominates push.

## Test plan
- Reset release, InstrReady=1, memory word i = i*3: InstrValid rises after 2nd edge, then Instruction 0,3,6,9 with InstrPC 0,4,8,12 on consecutive cycles.
- InstrReady low 4 cycles from PC 0: exactly 2 words buffered (0,3), ImemAddress held 8; release -> 0,3,6 delivered back-to-back, no loss or duplication.
- Redirect target 0x40 while buffer full and InstrReady=1: head accepted, InstrValid=0 next cycle, then Instruction 48 with InstrPC 0x40.
- Rst_n asserted mid-stream with buffer full: outputs clear immediately (asynchronous), restart delivers RESET_PC word first.
- With FETCH_BOUNDS_CHECK_EN, IMEM_WORDS=128: redirect to 0x1FC -> word 381 delivered, next PC 0x200 -> Fault=1, no further InstrValid; redirect to 0x42 -> Fault=1 directly.
- Without macro: redirect to 0x42 -> InstrPC 0x40, Fault stays 0.
